// File: rtl/decode_stage.sv
// RV64I instruction-decode stage: IF/ID holding register, decode, register-file
// read with writeback bypass, load-use stall, and a registered ID/EX output.
module decode_stage #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic [4:0]      read_reg1,
   output logic [4:0]      read_reg2,
   input  logic [XLEN-1:0] read_data1,
   input  logic [XLEN-1:0] read_data2,
   input  logic            wb_reg_write,
   input  logic [4:0]      wb_write_reg,
   input  logic [XLEN-1:0] wb_write_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [XLEN-1:0] out_imm,
   output logic [4:0]      out_rd,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_funct3,
   output logic            out_funct7b5,
   output logic            out_reg_write,
   output logic            out_alu_src_imm,
   output logic            out_mem_read,
   output logic            out_mem_write,
   output logic            out_branch,
   output logic            out_jump,
   output logic            out_word_op,
   output logic            out_illegal
);

   typedef enum logic [6:0] {
      OPC_LUI       = 7'b0110111,
      OPC_AUIPC     = 7'b0010111,
      OPC_JAL       = 7'b1101111,
      OPC_JALR      = 7'b1100111,
      OPC_BRANCH    = 7'b1100011,
      OPC_LOAD      = 7'b0000011,
      OPC_STORE     = 7'b0100011,
      OPC_OP_IMM    = 7'b0010011,
      OPC_OP        = 7'b0110011,
      OPC_OP_IMM_32 = 7'b0011011,
      OPC_OP_32     = 7'b0111011
   } opcode_e;

   logic            id_valid;
   logic [31:0]     id_instr;
   logic [XLEN-1:0] id_pc;

   opcode_e         opcode;
   logic            legal, use_rs1, use_rs2, alu_src_imm, word_op;
   logic            reg_write, mem_read, mem_write, branch, jump;
   logic [XLEN-1:0] imm, imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic [4:0]      rd;
   logic            hazard, ex_adv, id_fire;

   assign opcode = opcode_e'(id_instr[6:0]);

   assign imm_i = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};
   assign imm_s = {{(XLEN-12){id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
   assign imm_b = {{(XLEN-13){id_instr[31]}}, id_instr[31], id_instr[7],
                   id_instr[30:25], id_instr[11:8], 1'b0};
   assign imm_u = {{(XLEN-32){id_instr[31]}}, id_instr[31:12], 12'b0};
   assign imm_j = {{(XLEN-21){id_instr[31]}}, id_instr[31], id_instr[19:12],
                   id_instr[20], id_instr[30:21], 1'b0};

   // NOTE: every output of this block gets a default first, so no path through the case can infer a latch.
   always_comb begin
      legal       = 1'b0;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
      alu_src_imm = 1'b0;
      word_op     = 1'b0;
      imm         = '0;
      case (opcode)
         OPC_LUI, OPC_AUIPC: begin legal = 1'b1; alu_src_imm = 1'b1; imm = imm_u; end
         OPC_JAL:            begin legal = 1'b1; alu_src_imm = 1'b1; imm = imm_j; end
         OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
            legal = 1'b1; use_rs1 = 1'b1; alu_src_imm = 1'b1; imm = imm_i;
         end
         OPC_BRANCH:         begin legal = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_b; end
         OPC_STORE: begin
            legal = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; alu_src_imm = 1'b1; imm = imm_s;
         end
         OPC_OP:             begin legal = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
         OPC_OP_IMM_32: begin
            legal = 1'b1; use_rs1 = 1'b1; alu_src_imm = 1'b1; word_op = 1'b1; imm = imm_i;
         end
         OPC_OP_32:          begin legal = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; word_op = 1'b1; end
         default: ;
      endcase
   end

   // Illegal opcodes fall out as zero here because none of them match.
   assign reg_write = legal && (opcode != OPC_BRANCH) && (opcode != OPC_STORE);
   assign mem_read  = (opcode == OPC_LOAD);
   assign mem_write = (opcode == OPC_STORE);
   assign branch    = (opcode == OPC_BRANCH);
   assign jump      = (opcode == OPC_JAL) || (opcode == OPC_JALR);
   assign rd        = reg_write ? id_instr[11:7] : '0;

   assign read_reg1 = (id_valid && use_rs1) ? id_instr[19:15] : '0;
   assign read_reg2 = (id_valid && use_rs2) ? id_instr[24:20] : '0;

   assign rs1_data = (wb_reg_write && wb_write_reg != '0 && wb_write_reg == read_reg1)
                     ? wb_write_data : read_data1;
   assign rs2_data = (wb_reg_write && wb_write_reg != '0 && wb_write_reg == read_reg2)
                     ? wb_write_data : read_data2;

   // Unused operands read x0, and out_rd is nonzero here, so they can never match.
   assign hazard   = id_valid && out_valid && out_mem_read && (out_rd != '0) &&
                     ((out_rd == read_reg1) || (out_rd == read_reg2));
   assign ex_adv   = !out_valid || out_ready;
   assign id_fire  = id_valid && ex_adv && !hazard;
   assign in_ready = !flush && (!id_valid || id_fire);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         id_valid <= 1'b0;
         id_instr <= '0;
         id_pc    <= '0;
      end else if (in_valid && in_ready) begin
         id_valid <= 1'b1;
         id_instr <= in_instr;
         id_pc    <= in_pc;
      end else if (id_fire) begin
         id_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         out_valid       <= 1'b0;
         out_pc          <= '0;
         out_rs1_data    <= '0;
         out_rs2_data    <= '0;
         out_imm         <= '0;
         out_rd          <= '0;
         out_opcode      <= '0;
         out_funct3      <= '0;
         out_funct7b5    <= 1'b0;
         out_reg_write   <= 1'b0;
         out_alu_src_imm <= 1'b0;
         out_mem_read    <= 1'b0;
         out_mem_write   <= 1'b0;
         out_branch      <= 1'b0;
         out_jump        <= 1'b0;
         out_word_op     <= 1'b0;
         out_illegal     <= 1'b0;
      end else if (ex_adv) begin
         out_valid <= id_fire;
         if (id_fire) begin
            out_pc          <= id_pc;
            out_rs1_data    <= rs1_data;
            out_rs2_data    <= rs2_data;
            out_imm         <= imm;
            out_rd          <= rd;
            out_opcode      <= id_instr[6:0];
            out_funct3      <= id_instr[14:12];
            out_funct7b5    <= id_instr[30];
            out_reg_write   <= reg_write;
            out_alu_src_imm <= alu_src_imm;
            out_mem_read    <= mem_read;
            out_mem_write   <= mem_write;
            out_branch      <= branch;
            out_jump        <= jump;
            out_word_op     <= word_op;
            out_illegal     <= !legal;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// stream checked by an in-order scoreboard fed from an instruction-level model.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc, read_data1, read_data2, wb_write_data;
   logic [4:0]  read_reg1, read_reg2, wb_write_reg, out_rd;
   logic        wb_reg_write;
   logic [63:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
   logic [6:0]  out_opcode;
   logic [2:0]  out_funct3;
   logic        out_funct7b5, out_reg_write, out_alu_src_imm, out_mem_read;
   logic        out_mem_write, out_branch, out_jump, out_word_op, out_illegal;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(64)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .read_reg1(read_reg1), .read_reg2(read_reg2),
      .read_data1(read_data1), .read_data2(read_data2),
      .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
      .out_imm(out_imm), .out_rd(out_rd), .out_opcode(out_opcode),
      .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
      .out_reg_write(out_reg_write), .out_alu_src_imm(out_alu_src_imm),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_branch(out_branch), .out_jump(out_jump),
      .out_word_op(out_word_op), .out_illegal(out_illegal)
   );

   // Register file behaviour: combinational reads, x0 reads zero.
   logic [63:0] regs [32];
   assign read_data1 = regs[read_reg1];
   assign read_data2 = regs[read_reg2];

   localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67,
                          BR = 7'h63, LD = 7'h03, ST = 7'h23, OPI = 7'h13,
                          OPR = 7'h33, OPI32 = 7'h1B, OP32 = 7'h3B;

   typedef struct packed {
      logic [63:0] pc, rs1, rs2, imm;
      logic [4:0]  rd;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        f7b5;
      logic [7:0]  ctrl;  // reg_write alu_src_imm mem_read mem_write branch jump word_op illegal
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0, n_bad = 0, n_emit = 0;
   bit   sb_on = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc);
      exp_t e;
      logic [6:0] op;
      logic legal, u1, u2, rw;
      op = ins[6:0];
      e = '0;
      legal = op inside {LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR, OPI32, OP32};
      u1 = op inside {JALR, BR, LD, ST, OPI, OPR, OPI32, OP32};
      u2 = op inside {BR, ST, OPR, OP32};
      rw = legal && !(op inside {BR, ST});
      case (op)
         JALR, LD, OPI, OPI32: e.imm = 64'($signed(ins[31:20]));
         ST:         e.imm = 64'($signed({ins[31:25], ins[11:7]}));
         BR:         e.imm = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
         LUI, AUIPC: e.imm = 64'($signed({ins[31:12], 12'h000}));
         JAL:        e.imm = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
         default:    e.imm = 64'd0;
      endcase
      e.pc   = pc;
      e.rs1  = u1 ? regs[ins[19:15]] : 64'd0;
      e.rs2  = u2 ? regs[ins[24:20]] : 64'd0;
      e.rd   = rw ? ins[11:7] : 5'd0;
      e.opc  = op;
      e.f3   = ins[14:12];
      e.f7b5 = ins[30];
      e.ctrl = {rw, legal && !(op inside {OPR, OP32, BR}), op == LD, op == ST, op == BR,
                op == JAL || op == JALR, op == OPI32 || op == OP32, !legal};
      return e;
   endfunction

   // Scoreboard: sampled at negedge, i.e. the handshakes that the next rising edge completes.
   always @(negedge clk) begin
      if (sb_on && !reset && !flush) begin
         if (out_valid && out_ready) begin
            exp_t e;
            n_emit++;
            check("sb_has_entry", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
               e = q.pop_front();
               check("sb_pc", out_pc, e.pc);
               check("sb_rs1_data", out_rs1_data, e.rs1);
               check("sb_rs2_data", out_rs2_data, e.rs2);
               check("sb_imm", out_imm, e.imm);
               check("sb_fields", {out_rd, out_opcode, out_funct3, out_funct7b5},
                     {e.rd, e.opc, e.f3, e.f7b5});
               check("sb_ctrl", {out_reg_write, out_alu_src_imm, out_mem_read, out_mem_write,
                                 out_branch, out_jump, out_word_op, out_illegal}, e.ctrl);
            end
         end
         if (in_valid && in_ready) q.push_back(model(in_instr, in_pc));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction and hold it until the DUT takes it at a rising edge.
   task automatic feed(input logic [31:0] ins, input logic [63:0] pc);
      in_valid = 1'b1;
      in_instr = ins;
      in_pc    = pc;
      #1;
      for (int b = 0; !in_ready && b < 20; b++) begin
         @(posedge clk);
         #2;
      end
      check("feed_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
   endtask

   function automatic logic [31:0] mk_addi(input int rd, input int rs1, input int imm);
      logic [11:0] i12;
      logic [4:0]  d, s;
      i12 = 12'(imm);
      d   = 5'(rd);
      s   = 5'(rs1);
      return {i12, s, 3'b000, d, OPI};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [11];
      logic [31:0] r;
      ops = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR, OPI32, OP32};
      r = $urandom;
      if ($urandom_range(7) == 0) return r;
      return {r[31:7], ops[$urandom_range(10)]};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bubbles;
      logic [63:0] saved_r10;

      for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
      regs[0] = 64'd0;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
      out_ready = 1'b1; wb_reg_write = 1'b0; wb_write_reg = '0; wb_write_data = '0;
      repeat (2) tick();
      reset = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_pc", out_pc, 64'd0);
      check("rst_out_fields", {out_imm[31:0], out_rd, out_opcode, out_reg_write, out_illegal}, 64'd0);

      // Basic decode: ADDI x5,x0,0x7FF
      sb_on = 1'b1;
      feed(32'h7FF0_0293, 64'h1000);
      check("basic_read_reg1", 64'(read_reg1), 64'd0);
      check("basic_not_yet_valid", 64'(out_valid), 64'd0);
      tick();
      check("basic_out_valid", 64'(out_valid), 64'd1);
      check("basic_rd", 64'(out_rd), 64'd5);
      check("basic_imm", out_imm, 64'h7FF);
      check("basic_ctrl", {out_reg_write, out_alu_src_imm}, 64'b11);
      tick();
      check("basic_drain", 64'(out_valid), 64'd0);

      // Load-use: LD x6,0(x5) then ADD x7,x6,x6
      feed(32'h0002_B303, 64'h2000);
      feed(32'h0063_03B3, 64'h2004);
      check("lu_load_out", {out_valid, out_mem_read}, 64'b11);
      check("lu_in_ready_stalled", 64'(in_ready), 64'd0);
      bubbles = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (out_valid) break;
         bubbles++;
      end
      check("lu_bubbles", 64'(bubbles), 64'd1);
      check("lu_add_pc", out_pc, 64'h2004);
      check("lu_add_rd", 64'(out_rd), 64'd7);
      tick();

      // WB bypass on x10 while the register file still returns zero
      sb_on = 1'b0;
      saved_r10 = regs[10];
      regs[10] = 64'd0;
      feed(mk_addi(11, 10, 0), 64'h3000);
      wb_reg_write = 1'b1; wb_write_reg = 5'd10; wb_write_data = 64'h1234_5678_9ABC_DEF0;
      #1;
      check("byp_read_reg1", 64'(read_reg1), 64'd10);
      tick();
      check("byp_rs1_data", out_rs1_data, 64'h1234_5678_9ABC_DEF0);
      wb_reg_write = 1'b0;
      feed(mk_addi(11, 10, 0), 64'h3004);
      wb_reg_write = 1'b1; wb_write_reg = 5'd0;
      tick();
      check("byp_x0_no_bypass", out_rs1_data, 64'd0);
      wb_reg_write = 1'b0;
      regs[10] = saved_r10;
      tick();

      // Backpressure: four instructions, three stalled cycles
      sb_on = 1'b1;
      begin
         int n0;
         n0 = n_emit;
         out_ready = 1'b0;
         feed(mk_addi(1, 2, 1), 64'h4000);
         feed(mk_addi(2, 3, 2), 64'h4004);
         check("bp_full_in_ready", 64'(in_ready), 64'd0);
         for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_pc", out_pc, 64'h4000);
            check("bp_hold_rd_valid", {out_rd, out_valid}, {5'd1, 1'b1});
            check("bp_hold_in_ready", 64'(in_ready), 64'd0);
         end
         out_ready = 1'b1;
         feed(mk_addi(3, 4, 3), 64'h4008);
         feed(mk_addi(4, 5, 4), 64'h400C);
         repeat (4) tick();
         check("bp_emitted", 64'(n_emit - n0), 64'd4);
         check("bp_queue_empty", 64'(q.size()), 64'd0);
      end

      // Flush with both stages occupied
      sb_on = 1'b0;
      out_ready = 1'b0;
      feed(mk_addi(8, 3, 5), 64'h5000);
      feed(mk_addi(9, 3, 6), 64'h5004);
      flush = 1'b1;
      in_valid = 1'b1; in_instr = mk_addi(10, 0, 1); in_pc = 64'h5100;
      #1;
      check("fl_in_ready", 64'(in_ready), 64'd0);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      check("fl_out_valid", 64'(out_valid), 64'd0);
      check("fl_id_empty", 64'(read_reg1), 64'd0);
      out_ready = 1'b1;
      feed(32'h7FF0_0293, 64'h5200);
      check("fl_nothing_survived", 64'(out_valid), 64'd0);
      tick();
      check("fl_after_valid", 64'(out_valid), 64'd1);
      check("fl_after_pc", out_pc, 64'h5200);
      check("fl_after_imm", out_imm, 64'h7FF);
      tick();

      // Branch immediate (beq x0,x0,-4) and an illegal opcode
      sb_on = 1'b1;
      feed(32'hFE00_0EE3, 64'h6000);
      tick();
      check("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
      check("beq_branch_rw", {out_branch, out_reg_write}, 64'b10);
      feed(32'hFFFF_FFFF, 64'h6004);
      tick();
      check("ill_flags", {out_illegal, out_reg_write, out_mem_write}, 64'b100);

      // Randomized stream under random backpressure
      for (int i = 0; i < 400; i++) begin
         out_ready = ($urandom_range(3) != 0);
         in_valid  = ($urandom_range(2) != 0);
         in_instr  = rand_instr();
         in_pc     = {$urandom, $urandom & 32'hFFFF_FFFC};
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (6) tick();
      check("rand_queue_empty", 64'(q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
